// File: rtl/sysid_checker.sv
// Reads the system-ID slave's ID and timestamp words over Avalon-MM and flags
// whether both match the expected build values, with a per-read stall timeout.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h50CE_8A7D,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FIN} state_e;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic        auto_q;
  logic [15:0] wait_cnt_q;
  logic [15:0] wait_cnt_d;
  logic        timeout_hit;
  logic        addr_q, read_q, busy_q, done_q, match_q, tmo_q;
  logic [31:0] id_q, ts_q;

  // The stall that brings the count up to TIMEOUT_CYCLES ends the read.
  always_comb begin
    wait_cnt_d  = wait_cnt_q + 16'd1;
    timeout_hit = (wait_cnt_q == TIMEOUT_LAST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      auto_q     <= AUTO_START;
      wait_cnt_q <= '0;
      addr_q     <= 1'b0;
      read_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
      tmo_q      <= 1'b0;
      id_q       <= '0;
      ts_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start || auto_q) begin
            auto_q     <= 1'b0;
            state_q    <= RD_ID;
            read_q     <= 1'b1;
            addr_q     <= 1'b0;
            busy_q     <= 1'b1;
            match_q    <= 1'b0;
            tmo_q      <= 1'b0;
            wait_cnt_q <= '0;
          end
        end
        RD_ID: begin
          if (!master_waitrequest) begin
            id_q       <= master_readdata;
            state_q    <= RD_TS;
            addr_q     <= 1'b1;
            wait_cnt_q <= '0;
          end else if (timeout_hit) begin
            state_q <= FIN;
            read_q  <= 1'b0;
            tmo_q   <= 1'b1;
            match_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        RD_TS: begin
          if (!master_waitrequest) begin
            ts_q    <= master_readdata;
            state_q <= FIN;
            read_q  <= 1'b0;
            addr_q  <= 1'b0;
            done_q  <= 1'b1;
            match_q <= (id_q == EXPECTED_ID) && (master_readdata == EXPECTED_TIMESTAMP);
          end else if (timeout_hit) begin
            state_q <= FIN;
            read_q  <= 1'b0;
            addr_q  <= 1'b0;
            tmo_q   <= 1'b1;
            match_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign master_address  = addr_q;
  assign master_read     = read_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign match           = match_q;
  assign timeout_err     = tmo_q;
  assign id_value        = id_q;
  assign timestamp_value = ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench: slave model with programmable stall count, a default-parameter
// instance and a stuck-waitrequest instance with a short timeout.
module tb_sysid_checker;

  logic        clock = 1'b0;
  logic        reset_n, start, start2;
  logic [31:0] id_resp, ts_resp;
  int unsigned stall_cfg, stall_cnt;
  int          checks = 0, failures = 0;

  logic        m_addr, m_read, wr, busy, done, match, tmo;
  logic [31:0] rdata, id_v, ts_v;
  logic        m_addr2, m_read2, busy2, done2, match2, tmo2;
  logic [31:0] id_v2, ts_v2;

  always #5 clock = ~clock;

  assign wr    = m_read && (stall_cnt < stall_cfg);
  assign rdata = m_addr ? ts_resp : id_resp;

  always @(posedge clock or negedge reset_n)
    if (!reset_n)            stall_cnt <= 0;
    else if (!m_read || !wr) stall_cnt <= 0;
    else                     stall_cnt <= stall_cnt + 1;

  sysid_checker dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .master_address(m_addr), .master_read(m_read),
    .master_readdata(rdata), .master_waitrequest(wr),
    .busy(busy), .done(done), .match(match), .timeout_err(tmo),
    .id_value(id_v), .timestamp_value(ts_v)
  );

  sysid_checker #(.TIMEOUT_CYCLES(4), .AUTO_START(1'b0)) dut_tmo (
    .clock(clock), .reset_n(reset_n), .start(start2),
    .master_address(m_addr2), .master_read(m_read2),
    .master_readdata(32'h0), .master_waitrequest(1'b1),
    .busy(busy2), .done(done2), .match(match2), .timeout_err(tmo2),
    .id_value(id_v2), .timestamp_value(ts_v2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pulse start, then observe cycles 1..20 (cycle k follows edge k-1).
  task automatic run1(input int unsigned stalls, input bit poke,
                      output int done_cyc, output int rd_first, output int rd_last,
                      output int unstable, output int done_cnt);
    logic pr, pw, pa;
    done_cyc = 0; rd_first = 0; rd_last = 0; unstable = 0; done_cnt = 0;
    pr = 0; pw = 0; pa = 0;
    stall_cfg = stalls;
    @(negedge clock); start = 1'b1;
    @(posedge clock);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clock);
      start = poke && (cyc == 1 || cyc == 2);
      if (m_read) begin
        if (rd_first == 0) rd_first = cyc;
        rd_last = cyc;
        if (pr && pw && m_addr != pa) unstable++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      pr = m_read; pw = wr; pa = m_addr;
    end
    start = 1'b0;
  endtask

  int dc, rf, rl, us, dn, n2, rd2, a1;

  initial begin
    reset_n = 1'b0; start = 1'b0; start2 = 1'b0; stall_cfg = 0;
    id_resp = 32'h0; ts_resp = 32'h50CE8A7D;
    repeat (3) @(negedge clock);
    check("rst_read", m_read, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_match", match, 0);
    check("rst_id", id_v, 0);
    check("rst_ts", ts_v, 0);

    // Auto-start after release: done in cycle 3, exactly once.
    reset_n = 1'b1;
    dc = 0; dn = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clock);
      if (done) begin dn++; if (dc == 0) dc = cyc; end
    end
    check("auto_done_cyc", dc, 3);
    check("auto_done_cnt", dn, 1);
    check("auto_match", match, 1);
    check("noauto_busy", busy2, 0);

    run1(0, 0, dc, rf, rl, us, dn);
    check("zw_rd_first", rf, 1);
    check("zw_rd_last", rl, 2);
    check("zw_done_cyc", dc, 3);
    check("zw_match", match, 1);
    check("zw_tmo", tmo, 0);
    check("zw_ts", ts_v, 32'h50CE8A7D);

    ts_resp = 32'h50CE8A7E;
    run1(0, 0, dc, rf, rl, us, dn);
    check("bad_done_cyc", dc, 3);
    check("bad_match", match, 0);
    check("bad_tmo", tmo, 0);
    check("bad_ts", ts_v, 32'h50CE8A7E);
    ts_resp = 32'h50CE8A7D;

    run1(3, 0, dc, rf, rl, us, dn);
    check("ws_rd_first", rf, 1);
    check("ws_rd_last", rl, 8);
    check("ws_done_cyc", dc, 9);
    check("ws_unstable", us, 0);
    check("ws_match", match, 1);

    run1(0, 1, dc, rf, rl, us, dn);
    check("poke_done_cnt", dn, 1);
    check("poke_done_cyc", dc, 3);
    check("poke_busy", busy, 0);
    check("poke_match", match, 1);

    // Reset in RD_TS, then auto-start must complete once.
    stall_cfg = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    check("mid_addr", m_addr, 1);
    check("mid_read", m_read, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_read", m_read, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_match", match, 0);
    @(negedge clock); reset_n = 1'b1;
    dc = 0; dn = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clock);
      if (done) begin dn++; if (dc == 0) dc = cyc; end
    end
    check("rel_done_cnt", dn, 1);
    check("rel_match", match, 1);
    check("rel_ts", ts_v, 32'h50CE8A7D);

    // Held start retriggers from IDLE the edge after FIN.
    @(negedge clock); start = 1'b1;
    @(posedge clock);
    dc = 0; dn = 0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clock);
      if (done) begin dn++; dc = cyc; end
    end
    start = 1'b0;
    check("hold_done_cnt", dn, 2);
    check("hold_done2_cyc", dc, 7);
    repeat (6) @(negedge clock);

    // Stuck waitrequest with TIMEOUT_CYCLES=4.
    @(negedge clock); start2 = 1'b1;
    @(posedge clock);
    dc = 0; n2 = 0; rd2 = 0; a1 = 0;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clock);
      start2 = 1'b0;
      if (m_read2) begin rd2++; if (m_addr2) a1++; end
      if (done2) begin n2++; if (dc == 0) dc = cyc; end
    end
    check("to_read_cycles", rd2, 4);
    check("to_addr1", a1, 0);
    check("to_done_cyc", dc, 5);
    check("to_done_cnt", n2, 1);
    check("to_tmo", tmo2, 1);
    check("to_match", match2, 0);
    check("to_busy", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
